// File: rtl/bp_update_scheduler_if.sv
// Commit-side update bus and predictor update bus for bp_update_scheduler.
// The slave modport is the scheduler; the master modport is the commit/predictor side.
interface bp_update_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  upd_valid_i_0;
  logic                  upd_valid_i_1;
  logic                  upd_valid_i_2;
  logic [ADDR_WIDTH-1:0] upd_pc_i_0;
  logic [ADDR_WIDTH-1:0] upd_pc_i_1;
  logic [ADDR_WIDTH-1:0] upd_pc_i_2;
  logic                  upd_mispred_i_0;
  logic                  upd_mispred_i_1;
  logic                  upd_mispred_i_2;
  logic                  upd_ready_o;
  logic                  bp_update_valid_o;
  logic [ADDR_WIDTH-1:0] bp_update_pc_o;
  logic                  bp_misprediction_o;
  logic                  bp_ready_i;

  modport slave (
    input  upd_valid_i_0, upd_valid_i_1, upd_valid_i_2,
    input  upd_pc_i_0, upd_pc_i_1, upd_pc_i_2,
    input  upd_mispred_i_0, upd_mispred_i_1, upd_mispred_i_2,
    output upd_ready_o,
    output bp_update_valid_o, bp_update_pc_o, bp_misprediction_o,
    input  bp_ready_i
  );

  modport master (
    output upd_valid_i_0, upd_valid_i_1, upd_valid_i_2,
    output upd_pc_i_0, upd_pc_i_1, upd_pc_i_2,
    output upd_mispred_i_0, upd_mispred_i_1, upd_mispred_i_2,
    input  upd_ready_o,
    input  bp_update_valid_o, bp_update_pc_o, bp_misprediction_o,
    output bp_ready_i
  );
endinterface

// File: rtl/bp_update_scheduler.sv
// Buffers up to three resolved-branch updates per cycle in an in-order FIFO and
// drains them one per cycle to the predictor; a burst that does not fit is dropped whole.
module bp_update_scheduler #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  bp_update_scheduler_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                         overflow_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [ADDR_WIDTH:0] mem_q [DEPTH];

  logic [2:0]          valid;
  logic [ADDR_WIDTH:0] slot_data [3];
  logic [1:0]          slot_off [3];
  logic [1:0]          n_enq;
  logic                ready;
  logic                deq;
  logic                not_empty;
  logic [ADDR_WIDTH:0] head;

  always_comb begin
    valid        = {bus.upd_valid_i_2, bus.upd_valid_i_1, bus.upd_valid_i_0};
    slot_data[0] = {bus.upd_mispred_i_0, bus.upd_pc_i_0};
    slot_data[1] = {bus.upd_mispred_i_1, bus.upd_pc_i_1};
    slot_data[2] = {bus.upd_mispred_i_2, bus.upd_pc_i_2};
    // Each valid slot lands after the valid slots below it, compacting gaps.
    slot_off[0]  = 2'd0;
    slot_off[1]  = {1'b0, valid[0]};
    slot_off[2]  = {1'b0, valid[0]} + {1'b0, valid[1]};
    n_enq        = slot_off[2] + {1'b0, valid[2]};
  end

  always_comb begin
    not_empty  = (count_q != '0);
    ready      = (count_q <= CW'(DEPTH - 3));
    deq        = not_empty && bus.bp_ready_i;
    rd_ptr_d   = rd_ptr_q + (deq ? PW'(1) : '0);
    wr_ptr_d   = wr_ptr_q + (ready ? PW'(n_enq) : '0);
    count_d    = count_q + (ready ? CW'(n_enq) : '0) - (deq ? CW'(1) : '0);
    overflow_d = !ready && (valid != 3'b000);
    head       = not_empty ? mem_q[rd_ptr_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && ready) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (valid[i]) begin
          mem_q[wr_ptr_q + PW'(slot_off[i])] <= slot_data[i];
        end
      end
    end
  end

  assign bus.upd_ready_o        = ready;
  assign bus.bp_update_valid_o  = not_empty;
  assign bus.bp_update_pc_o     = head[ADDR_WIDTH-1:0];
  assign bus.bp_misprediction_o = head[ADDR_WIDTH];
  assign occupancy_o            = count_q;
  assign overflow_o             = overflow_q;
endmodule
